// File: rtl/cpu_pkg.sv
// Shared ISA constants and load-FSM state type for the 8-bit microprocessor.
// The halt word is "j -1", a jump that targets itself, so a stray fetch parks the CPU.
package cpu_pkg;

    localparam int OP_W    = 2;
    localparam int REG_W   = 2;
    localparam int IMM_W   = 2;
    localparam int INSTR_W = OP_W + 2 * REG_W + IMM_W;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_LW  = 2'b01;
    localparam logic [OP_W-1:0] OP_SW  = 2'b10;
    localparam logic [OP_W-1:0] OP_J   = 2'b11;

    localparam logic [INSTR_W-1:0] HALT_INSTR = {OP_J, 2'b00, 2'b00, 2'b11};

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Program-load controller: sequential write pointer from address 0, loaded
// length and sticky overflow flag for the loadable instruction memory.
module imem_load_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 8,
    parameter int MEM_AW = 5,
    parameter int PTR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic              i_load_last,
    output load_state_t       o_state,
    output logic              o_load_ready,
    output logic              o_wr_en,
    output logic [MEM_AW-1:0] o_wr_addr,
    output logic [ADDR_W:0]   o_prog_len,
    output logic              o_load_error
);

    localparam int LEN_W = ADDR_W + 1;

    load_state_t      r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [LEN_W-1:0] r_prog_len;
    logic             r_load_error;
    logic             w_wr_en;
    logic             w_last_slot;

    // Ready depends on state only, so a word is taken on every valid cycle.
    assign w_wr_en     = i_load_valid & (r_state == LOAD);
    assign w_last_slot = (r_wr_ptr == PTR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_prog_len   <= '0;
            r_load_error <= 1'b0;
        end else if (r_state == IDLE) begin
            if (i_load_start) begin
                r_state      <= LOAD;
                r_wr_ptr     <= '0;
                r_prog_len   <= '0;
                r_load_error <= 1'b0;
            end
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_load_last) begin
                r_state    <= IDLE;
                r_prog_len <= LEN_W'(r_wr_ptr + PTR_W'(1));
            end else if (w_last_slot) begin
                // Array full without a terminating word: keep what fits, flag it.
                r_state      <= IDLE;
                r_prog_len   <= LEN_W'(DEPTH);
                r_load_error <= 1'b1;
            end
        end
    end

    assign o_state      = r_state;
    assign o_load_ready = (r_state == LOAD);
    assign o_wr_en      = w_wr_en;
    assign o_wr_addr    = r_wr_ptr[MEM_AW-1:0];
    assign o_prog_len   = r_prog_len;
    assign o_load_error = r_load_error;

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory with a combinational fetch port; any
// fetch outside the loaded program or during a load returns the halt word.
module imem_loadable #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 8,
    parameter int                DEPTH      = 32,
    parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(cpu_pkg::HALT_INSTR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_hold,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   prog_len,
    output logic              load_error
);

    import cpu_pkg::*;

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int LEN_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];

    load_state_t       w_state;
    logic              w_load_ready;
    logic              w_wr_en;
    logic [MEM_AW-1:0] w_wr_addr;
    logic [LEN_W-1:0]  w_prog_len;
    logic              w_load_error;
    logic              w_in_prog;
    logic              w_in_depth;
    logic [MEM_AW-1:0] w_rd_addr;

    imem_load_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .MEM_AW (MEM_AW),
        .PTR_W  (PTR_W)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .i_load_start (load_start),
        .i_load_valid (load_valid),
        .i_load_last  (load_last),
        .o_state      (w_state),
        .o_load_ready (w_load_ready),
        .o_wr_en      (w_wr_en),
        .o_wr_addr    (w_wr_addr),
        .o_prog_len   (w_prog_len),
        .o_load_error (w_load_error)
    );

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= load_data;
        end
    end

    // Both range tests use the full zero-extended address, so high address
    // bits never alias onto a valid word even when ADDR_W exceeds MEM_AW.
    assign w_in_prog  = ({1'b0, read_address} < w_prog_len);
    assign w_in_depth = ({1'b0, read_address} < LEN_W'(DEPTH));
    assign w_rd_addr  = read_address[MEM_AW-1:0];

    assign instruction = ((w_state == IDLE) && w_in_prog && w_in_depth) ?
                         r_mem[w_rd_addr] : HALT_INSTR;

    assign cpu_hold   = w_load_ready;
    assign load_ready = w_load_ready;
    assign prog_len   = w_prog_len;
    assign load_error = w_load_error;

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, run-time loadable instruction memory for the 8-bit microprocessor; replaces the fixed-contents instruction ROM.
- The CPU fetch port stays combinational: instruction follows read_address in the same cycle, as the single-cycle datapath requires.
- A valid/ready load port writes a new program sequentially from address 0.
- Fetches outside the loaded program, or during a load, return a self-loop halt word instead of X.

Parameters:
- DATA_W, 8, instruction width in bits.
- ADDR_W, 8, read_address width in bits.
- DEPTH, 32, number of instruction words; must satisfy DEPTH <= 2**ADDR_W.
- HALT_INSTR, 8'hC3, word returned for invalid fetches ("j -1": jumps to itself).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- read_address  in  ADDR_W  CPU fetch address (PC).
- instruction  out  DATA_W  fetched word; combinational.
- cpu_hold  out  1  high while a load is in progress; the CPU must not advance its PC.
- load_start  in  1  one-cycle pulse that begins a program load.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  program word to write.
- load_last  in  1  qualifies the final word of the program.
- load_ready  out  1  memory accepts a word this cycle.
- prog_len  out  ADDR_W+1  number of valid words currently loaded.
- load_error  out  1  sticky flag: the program overflowed DEPTH.

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, prog_len=0, load_error=0, load_ready=0, cpu_hold=0.
  - The memory array is not cleared.
  - Because prog_len=0, every fetch after reset returns HALT_INSTR.
- Fetch (combinational): instruction = mem[read_address] only when all of these hold:
  - state==IDLE;
  - read_address < prog_len;
  - read_address < DEPTH.
  - Otherwise instruction = HALT_INSTR. It is never X.
- State machine:
  - IDLE -> LOAD when load_start=1. In that same edge: wr_ptr<=0, prog_len<=0, load_error<=0.
  - LOAD:
    - load_ready=1 and cpu_hold=1.
    - A word is accepted on a clock edge where load_valid & load_ready.
    - On accept: mem[wr_ptr]<=load_data, wr_ptr<=wr_ptr+1.
  - LOAD -> IDLE when an accepted word has load_last=1. In that edge: prog_len<=wr_ptr+1.
  - LOAD -> IDLE on overflow, i.e. an accepted word at wr_ptr==DEPTH-1 with load_last=0. In that edge:
    - prog_len<=DEPTH;
    - load_error<=1.
    - Further words are not accepted, because load_ready is 0 in IDLE.
- Timing:
  - A write is visible to a fetch starting from the first cycle back in IDLE.
  - Minimum load time for N words is 1+N cycles.
  - Zero-wait-state: load_ready does not depend on load_valid.
- Simultaneous events:
  - load_start during LOAD is ignored; the load is not restarted.
  - load_start together with load_valid in IDLE: only the start is taken. The word is not written, because load_ready=0 in that cycle.
  - load_last without load_valid has no effect.
- Reset mid-load: returns to IDLE with prog_len=0. Partially written words remain in the array but are unreachable.
- Width rules:
  - wr_ptr is $clog2(DEPTH)+1 bits wide.
  - The comparison with prog_len is unsigned and zero-extended.
  - read_address values >= DEPTH must not index the array. This also applies when ADDR_W > $clog2(DEPTH).

Decomposition:
- Shared package (cpu_pkg):
  - ISA field widths (OP_W=2, REG_W=2, IMM_W=2);
  - opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11;
  - HALT_INSTR={OP_J,2'b00,2'b00,2'b11};
  - the load FSM state enum {IDLE, LOAD}.
- Natural sub-module: imem_load_ctrl (FSM, wr_ptr, prog_len, load_error).
- The array and fetch mux stay in the top level.

Test Plan:
- Reset, then fetch addresses 0, 5 and 31 -> instruction=8'hC3 on each; prog_len=0; cpu_hold=0.
- Load 14 words (8'h49, 8'hC1, 8'h18, 8'hA9, ...) with load_last on the 14th, load_valid continuously high -> load_ready high for 14 cycles; prog_len=14; fetch 3 -> 8'hA9; fetch 14 -> 8'hC3.
- Same load with load_valid toggling 1,0,1,0 -> only valid cycles are written; contents match the previous test; cpu_hold high throughout LOAD and low after.
- Stream 33 words with no load_last, DEPTH=32 -> 32 words accepted; load_error=1; prog_len=32; load_ready=0 after the 32nd word; word 33 is not written.
- Assert reset after 5 of 10 words -> IDLE, prog_len=0, all fetches 8'hC3. Then start a new load -> load_error cleared; the new program is readable.
- Pulse load_start again at word 3 of a load -> ignored; wr_ptr continues to 4; the final prog_len equals the total number of words sent.
